// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler slice.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  localparam logic [7:0] NEWLINE = 8'h0A;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: load a byte while idle, start bit appears on the next clock.
module uart_tx_serializer
  import uart_sched_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  ser_state_t    state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_d;
  logic          baud_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '1;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    baud_end  = (baud == BAUD_LAST);
    unique case (state)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          baud_d  = '0;
          shreg_d = data;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          baud_d    = '0;
          bit_idx_d = '0;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b1, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next-state view so the line changes on the same edge as the state
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-channel round-robin arbiter with optional line lock in front of the shared 8N1 TX pin.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 434,
  parameter int unsigned LOCK_ON_NL   = 1,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LED_HOLD     = 2 ** 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       locked,
  output logic       tx_led
);

  localparam int unsigned LCW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);
  localparam int unsigned LEDW = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;
  localparam logic [LEDW-1:0] LED_INIT = LEDW'(LED_HOLD);

  logic            ser_busy;
  logic            idle;
  logic            winner;
  logic            win_valid;
  logic            accept;
  logic            owner_valid;
  logic [7:0]      acc_data;
  logic [LCW-1:0]  lock_cnt;
  logic [LEDW-1:0] led_cnt;

  assign idle        = !ser_busy;
  assign owner_valid = grant_id ? req1_valid : req0_valid;

  always_comb begin
    winner    = grant_id;
    win_valid = 1'b0;
    if (locked) begin
      winner    = grant_id;
      win_valid = owner_valid;
    end else if (req0_valid && req1_valid) begin
      winner    = !grant_id;
      win_valid = 1'b1;
    end else if (req1_valid) begin
      winner    = 1'b1;
      win_valid = 1'b1;
    end else if (req0_valid) begin
      winner    = 1'b0;
      win_valid = 1'b1;
    end
  end

  // readies are gated by rst so nothing can be accepted while reset is held
  assign accept     = idle && win_valid && !rst;
  assign req0_ready = accept && !winner;
  assign req1_ready = accept && winner;
  assign acc_data   = winner ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= 1'b0;
      locked   <= 1'b0;
      lock_cnt <= '0;
    end else if (accept) begin
      grant_id <= winner;
      locked   <= (LOCK_ON_NL != 0) && (acc_data != NEWLINE);
      lock_cnt <= '0;
    end else if (locked && idle && !owner_valid) begin
      if (lock_cnt == LOCK_LAST) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  // hold counter is reloaded every busy cycle, so it only runs down after the last frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_cnt <= '0;
    end else if (ser_busy) begin
      led_cnt <= LED_INIT;
    end else if (led_cnt != '0) begin
      led_cnt <= led_cnt - 1'b1;
    end
  end

  assign tx_led = ser_busy || (led_cnt != '0);
  assign busy   = ser_busy;

  uart_tx_serializer #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .data(acc_data),
    .tx  (tx),
    .busy(ser_busy)
  );

endmodule
